// File: rtl/add_serial_seq.sv
// add_serial_seq
//   Operand sequencer and result collector for the 8-bit serial adder
//   add_serial. Operand pairs are queued in a 2-entry FIFO, launched one at a
//   time with a single-cycle add_en pulse, and each sum is captured after the
//   adder's fixed latency and offered on a valid/ready result port.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset (adder's active-high rst = ~rst)
//   in_valid   : operand pair offered
//   in_ready   : FIFO can accept a pair
//   in_a, in_b : operands
//   add_en     : launch pulse to adder en
//   add_a/b    : operands to adder, held at the FIFO head for the whole op
//   add_out    : adder result, sampled only at the capture edge
//   res_valid  : captured sum available
//   res_ready  : consumer accepts the sum
//   res_sum    : captured sum
//   busy       : sequencer not idle
//   ops_done   : completed-operation counter, wraps
module add_serial_seq #(
  parameter int WIDTH      = 8,
  parameter int ADD_CYCLES = 9,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             add_en,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam int CW = $clog2(ADD_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH-1:0] fifo_a_r [0:1];
  logic [WIDTH-1:0] fifo_b_r [0:1];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       occ_r;
  logic             rdy_en_r;

  logic             res_valid_r;
  logic [WIDTH-1:0] res_sum_r;
  logic [CNT_W-1:0] ops_done_r;

  logic             push_s;
  logic             capture_s;
  logic             have_op_s;
  logic             slot_free_s;
  logic             add_en_s;
  logic             busy_s;

  // in_ready is held low during reset and rises one cycle after release.
  assign in_ready    = rdy_en_r & (occ_r != 2'd2);
  assign push_s      = in_valid & in_ready;
  assign capture_s   = (state_r == WAIT) && (cnt_r == CW'(1));
  // A pair being pushed this cycle lands at the head when the FIFO is empty,
  // so it can be launched straight away.
  assign have_op_s   = (occ_r != 2'd0) | push_s;
  // A result being accepted this cycle frees the slot long before the next
  // capture, so launching alongside the acceptance is safe.
  assign slot_free_s = ~res_valid_r | res_ready;

  assign add_a     = fifo_a_r[rd_ptr_r];
  assign add_b     = fifo_b_r[rd_ptr_r];
  assign add_en    = add_en_s;
  assign busy      = busy_s;
  assign res_valid = res_valid_r;
  assign res_sum   = res_sum_r;
  assign ops_done  = ops_done_r;

  // FSM state register and latency counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= CW'(0);
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        LAUNCH:  cnt_r <= CW'(ADD_CYCLES);
        WAIT:    cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= CW'(0);
      endcase
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (have_op_s && slot_free_s) state_nxt_s = LAUNCH;
        else                          state_nxt_s = IDLE;
      end
      LAUNCH: state_nxt_s = WAIT;
      WAIT: begin
        if (capture_s) state_nxt_s = IDLE;
        else           state_nxt_s = WAIT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state.
  always_comb begin
    add_en_s = 1'b0;
    busy_s   = 1'b0;
    case (state_r)
      IDLE: begin
        add_en_s = 1'b0;
        busy_s   = 1'b0;
      end
      LAUNCH: begin
        add_en_s = 1'b1;
        busy_s   = 1'b1;
      end
      WAIT: begin
        add_en_s = 1'b0;
        busy_s   = 1'b1;
      end
      default: begin
        add_en_s = 1'b0;
        busy_s   = 1'b0;
      end
    endcase
  end

  // Operand FIFO: storage, 1-bit wrapping pointers, occupancy. Pop at capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_a_r[0] <= {WIDTH{1'b0}};
      fifo_a_r[1] <= {WIDTH{1'b0}};
      fifo_b_r[0] <= {WIDTH{1'b0}};
      fifo_b_r[1] <= {WIDTH{1'b0}};
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= 1'b0;
      occ_r       <= 2'd0;
      rdy_en_r    <= 1'b0;
    end else begin
      rdy_en_r <= 1'b1;
      if (push_s) begin
        fifo_a_r[wr_ptr_r] <= in_a;
        fifo_b_r[wr_ptr_r] <= in_b;
        wr_ptr_r           <= ~wr_ptr_r;
      end
      if (capture_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, capture_s})
        2'b10:   occ_r <= occ_r + 2'd1;
        2'b01:   occ_r <= occ_r - 2'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Result slot and completed-operation counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid_r <= 1'b0;
      res_sum_r   <= {WIDTH{1'b0}};
      ops_done_r  <= {CNT_W{1'b0}};
    end else begin
      if (capture_s) begin
        res_valid_r <= 1'b1;
        res_sum_r   <= add_out;
        ops_done_r  <= ops_done_r + CNT_W'(1);
      end else if (res_valid_r && res_ready) begin
        res_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_add_serial_seq.sv
// Self-checking bench for add_serial_seq with an ideal adder model and a
// result scoreboard. A second instance with a 4-bit counter checks wrap.
module tb_add_serial_seq;

  localparam int ADD_CYCLES = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       res_ready = 1'b0;
  logic [7:0] add_out = 8'h00;

  logic        in_ready, add_en, res_valid, busy;
  logic [7:0]  add_a, add_b, res_sum;
  logic [15:0] ops_done;

  logic        in_ready4, add_en4, res_valid4, busy4;
  logic [7:0]  add_a4, add_b4, res_sum4;
  logic [3:0]  ops_done4;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int launch_cyc = -100;
  int last_launch = -1;
  int en_count = 0;
  int n_push = 0;
  bit spacing_chk = 1'b0;
  logic [7:0] exp_q[$];

  add_serial_seq #(.WIDTH(8), .ADD_CYCLES(ADD_CYCLES), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .add_en(add_en), .add_a(add_a), .add_b(add_b),
    .add_out(add_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .busy(busy), .ops_done(ops_done)
  );

  add_serial_seq #(.WIDTH(8), .ADD_CYCLES(ADD_CYCLES), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .add_en(add_en4), .add_a(add_a4), .add_b(add_b4),
    .add_out(add_out), .res_valid(res_valid4), .res_ready(res_ready),
    .res_sum(res_sum4), .busy(busy4), .ops_done(ops_done4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ideal adder: sum valid from ADD_CYCLES cycles after en, garbage before.
  always @(negedge clk) begin
    if (add_en) launch_cyc = cyc;
    if (cyc - launch_cyc >= ADD_CYCLES) add_out = add_a + add_b;
    else                                add_out = ~(add_a + add_b);
  end

  // Scoreboard on accepted results; launch pulse accounting.
  always @(negedge clk) begin
    if (rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) check_eq("sb_underflow", 32'(res_sum), 32'hFFFF_FFFF);
      else                   check_eq("sum", 32'(res_sum), 32'(exp_q.pop_front()));
    end
    if (add_en) begin
      en_count++;
      if (spacing_chk && last_launch >= 0) check_eq("launch_spacing", 32'(cyc - last_launch), 32'(ADD_CYCLES + 2));
      last_launch = cyc;
    end
  end

  // Called just after a rising edge; returns just after the push edge.
  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int t;
    logic [7:0] s;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (t == 100) begin
      check_eq("push_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      s = a + b;
      exp_q.push_back(s);
      n_push++;
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 600; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !res_valid) break;
    end
    if (t == 600) check_eq("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_add_en"}, 32'(add_en), 32'd0);
    check_eq({tag, "_add_ab"}, 32'({add_a, add_b}), 32'd0);
    check_eq({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check_eq({tag, "_res_sum"}, 32'(res_sum), 32'd0);
    check_eq({tag, "_ops_done"}, 32'(ops_done), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int en0;
    logic seen;
    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single operation with exact timing
    res_ready = 1'b0;
    push(8'h12, 8'h34);
    @(negedge clk);
    check_eq("single_launch", 32'(add_en), 32'd1);
    check_eq("single_ab_c1", 32'({add_a, add_b}), 32'h1234);
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      check_eq("single_en_low", 32'(add_en), 32'd0);
      check_eq("single_ab_hold", 32'({add_a, add_b}), 32'h1234);
    end
    check_eq("single_no_early_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    check_eq("single_valid", 32'(res_valid), 32'd1);
    check_eq("single_sum", 32'(res_sum), 32'h46);
    check_eq("single_ops_done", 32'(ops_done), 32'd1);
    check_eq("single_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1 res_ready = 1'b1;
    wait_idle();

    // Overflow / zero with back-to-back input pressure
    en0 = en_count;
    last_launch = -1;
    spacing_chk = 1'b1;
    push(8'hFF, 8'h01);
    push(8'h80, 8'h80);
    @(negedge clk);
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    push(8'h7F, 8'h01);
    wait_idle();
    spacing_chk = 1'b0;
    check_eq("bp_in_launches", 32'(en_count - en0), 32'd3);

    // Output back-pressure: result held, no relaunch until accepted
    res_ready = 1'b0;
    en0 = en_count;
    push(8'h11, 8'h22);
    push(8'h33, 8'h44);
    push(8'h55, 8'h66);
    repeat (20) @(negedge clk);
    check_eq("bp_out_no_relaunch", 32'(en_count - en0), 32'd1);
    check_eq("bp_out_valid", 32'(res_valid), 32'd1);
    check_eq("bp_out_sum_hold", 32'(res_sum), 32'h33);
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("launch_after_accept", 32'(add_en), 32'd1);
    wait_idle();

    // Reset in the middle of WAIT
    push(8'hAA, 8'h11);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_all_zero("midrst");
    void'(exp_q.pop_back());
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen = seen | res_valid;
    end
    check_eq("no_result_after_rst", 32'(seen), 32'd0);
    @(posedge clk);
    #1;

    // Fresh traffic after reset; 17 ops wraps the 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      push(8'(i * 13 + 7), 8'(i * 29 + 200));
    end
    wait_idle();
    check_eq("ops_done_17", 32'(ops_done), 32'd17);
    check_eq("ops_done_wrap4", 32'(ops_done4), 32'd1);
    check_eq("one_en_per_push", 32'(en_count), 32'(n_push));
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    check_eq("watchdog", 32'd0, 32'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
